// File: rtl/hdmi_rd_burst_ctrl.sv
// Read-burst controller feeding the HDMI pixel FIFO from DDR over an IPIF master port.
// Issues one fixed-length read command per request, with a one-deep pending slot.
module hdmi_rd_burst_ctrl #(
   parameter int BURST_BYTES = 256,
   parameter int C_ADDR_W    = 32
) (
   input  logic                Bus2IP_Clk,
   input  logic                Bus2IP_Resetn,
   input  logic                go_fill_fifo,
   input  logic [C_ADDR_W-1:0] ddr_addr_to_read,
   input  logic                flush,
   output logic                IP2Bus_MstRd_Req,
   output logic [C_ADDR_W-1:0] IP2Bus_Mst_Addr,
   output logic [11:0]         IP2Bus_Mst_Length,
   input  logic                Bus2IP_Mst_CmdAck,
   input  logic                Bus2IP_Mst_Cmplt,
   input  logic                Bus2IP_Mst_Error,
   input  logic [31:0]         Bus2IP_MstRd_d,
   input  logic                Bus2IP_MstRd_src_rdy_n,
   output logic                IP2Bus_MstRd_dst_rdy_n,
   input  logic                fifo_full,
   output logic                fifo_wr_en,
   output logic [31:0]         fifo_wr_data,
   output logic                busy,
   output logic                overrun,
   output logic                bus_err
);

   localparam int BEATS = BURST_BYTES / 4;
   localparam int CNT_W = ($clog2(BEATS + 1) > 7) ? $clog2(BEATS + 1) : 7;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   // A 4096-byte burst wraps to 0 in the 12-bit length field.
   localparam logic [11:0] BURST_LEN = 12'(BURST_BYTES);

   if ((BURST_BYTES % 4) != 0 || BURST_BYTES < 4 || BURST_BYTES > 4096) begin : g_bad_burst
      $error("BURST_BYTES must be a multiple of 4 in 4..4096");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_XFER  = 2'd2,
      S_CMPLT = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                pend_vld_q, pend_vld_d;
   logic [C_ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [C_ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic                overrun_q, overrun_d;
   logic                bus_err_q, bus_err_d;

   logic beat;
   logic last_beat;
   logic go_ok;
   logic launch_pend;
   logic queue_req;

   assign IP2Bus_MstRd_dst_rdy_n = (state_q == S_XFER) ? fifo_full : 1'b1;
   assign beat         = ~Bus2IP_MstRd_src_rdy_n & ~IP2Bus_MstRd_dst_rdy_n;
   assign last_beat    = beat & (cnt_q == LAST_BEAT);
   assign fifo_wr_en   = beat;
   assign fifo_wr_data = Bus2IP_MstRd_d;

   assign IP2Bus_MstRd_Req  = (state_q == S_REQ);
   assign IP2Bus_Mst_Addr   = cmd_addr_q;
   assign IP2Bus_Mst_Length = BURST_LEN;
   assign busy              = (state_q != S_IDLE);
   assign overrun           = overrun_q;
   assign bus_err           = bus_err_q;

   // flush wins over a same-cycle request, which is then silently dropped.
   assign go_ok       = go_fill_fifo & ~flush;
   assign launch_pend = (state_q == S_IDLE) & pend_vld_q & ~flush;
   // A new pulse goes to the pending slot unless an idle FSM takes it directly.
   assign queue_req   = go_ok & ((state_q != S_IDLE) | launch_pend);

   always_comb begin
      // NOTE: every next-state signal gets a default before the case so no
      // path leaves it unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      cmd_addr_d  = cmd_addr_q;
      overrun_d   = overrun_q;
      bus_err_d   = bus_err_q | Bus2IP_Mst_Error;

      unique case (state_q)
         S_IDLE: begin
            if (launch_pend) begin
               cmd_addr_d = pend_addr_q;
               state_d    = S_REQ;
            end else if (go_ok) begin
               cmd_addr_d = ddr_addr_to_read;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (Bus2IP_Mst_CmdAck) state_d = S_XFER;
         end
         S_XFER: begin
            if (last_beat) begin
               cnt_d   = '0;
               state_d = S_CMPLT;
            end else if (beat) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (Bus2IP_Mst_Cmplt) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (!last_beat) bus_err_d = 1'b1;
            end
         end
         S_CMPLT: begin
            if (Bus2IP_Mst_Cmplt) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         pend_vld_d = 1'b0;
      end else if (queue_req) begin
         if (!pend_vld_q || launch_pend) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = ddr_addr_to_read;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (launch_pend) begin
         pend_vld_d = 1'b0;
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values; the reset branch is asynchronous and clears everything.
   always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
      if (!Bus2IP_Resetn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         cmd_addr_q  <= '0;
         overrun_q   <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         cmd_addr_q  <= cmd_addr_d;
         overrun_q   <= overrun_d;
         bus_err_q   <= bus_err_d;
      end
   end

endmodule

// File: doc/hdmi_rd_burst_ctrl.md
HDMI_RD_BURST_CTRL -- requirements
Module: hdmi_rd_burst_ctrl

Interface
REQ-001 SHALL have parameter BURST_BYTES, default 256, bytes per read burst (half FIFO; 64 words); SHALL be a multiple of 4 and in the range 4 to 4096.
REQ-002 SHALL have parameter C_ADDR_W, default 32, address width.
REQ-003 Bus2IP_Clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Bus2IP_Resetn  in  1  asynchronous active-low reset.
REQ-005 go_fill_fifo  in  1  one-cycle burst request pulse.
REQ-006 ddr_addr_to_read  in  32  burst byte address, valid in the go_fill_fifo cycle.
REQ-007 flush  in  1  frame restart (vsync); discards any queued request.
REQ-008 IP2Bus_MstRd_Req  out  1  master read command request.
REQ-009 IP2Bus_Mst_Addr  out  32  command address.
REQ-010 IP2Bus_Mst_Length  out  12  command length in bytes; always BURST_BYTES.
REQ-011 Bus2IP_Mst_CmdAck  in  1  command accepted.
REQ-012 Bus2IP_Mst_Cmplt  in  1  transfer complete.
REQ-013 Bus2IP_Mst_Error  in  1  transfer error.
REQ-014 Bus2IP_MstRd_d  in  32  read data.
REQ-015 Bus2IP_MstRd_src_rdy_n  in  1  read data valid, active-low.
REQ-016 IP2Bus_MstRd_dst_rdy_n  out  1  ready to accept data, active-low.
REQ-017 fifo_full  in  1  pixel FIFO full.
REQ-018 fifo_wr_en  out  1  FIFO write strobe.
REQ-019 fifo_wr_data  out  32  FIFO write data.
REQ-020 busy  out  1  a burst is in progress.
REQ-021 overrun  out  1  sticky flag: a request was dropped.
REQ-022 bus_err  out  1  sticky flag: a bus error was seen.

Function
REQ-023 The FSM SHALL have states IDLE, REQ, XFER and CMPLT.
REQ-024 In IDLE, on go_fill_fifo or a valid pending entry, the FSM SHALL latch the address into cmd_addr and go to REQ the next cycle; a pending entry takes priority, and the new pulse then queues.
REQ-025 In REQ, IP2Bus_MstRd_Req SHALL be 1 and IP2Bus_Mst_Addr SHALL equal cmd_addr; on Bus2IP_Mst_CmdAck the FSM SHALL go to XFER and Req SHALL deassert the same edge.
REQ-026 IP2Bus_MstRd_dst_rdy_n SHALL equal fifo_full in XFER and SHALL be 1 in every other state.
REQ-027 A beat SHALL occur when src_rdy_n=0 and dst_rdy_n=0; on a beat, fifo_wr_en SHALL be 1 and fifo_wr_data SHALL equal Bus2IP_MstRd_d in the same cycle (combinational, zero latency).
REQ-028 A 7-bit beat counter SHALL count beats; at BURST_BYTES/4 beats the FSM SHALL go to CMPLT and the counter SHALL clear.
REQ-029 In XFER or CMPLT, Bus2IP_Mst_Cmplt SHALL return the FSM to IDLE, even if beats are still missing; a short burst SHALL set bus_err.
REQ-030 Bus2IP_Mst_Error in any state SHALL set bus_err (sticky until reset); the burst otherwise proceeds.
REQ-031 go_fill_fifo while not in IDLE SHALL store the address in a one-deep pending register; if pending is already valid, the new request SHALL be dropped, the old entry kept, and overrun set (sticky).
REQ-032 flush SHALL clear pending valid in the same edge and SHALL NOT abort the burst in flight.
REQ-033 flush and go_fill_fifo in the same cycle: flush SHALL take precedence, and the request SHALL be dropped without setting overrun.
REQ-034 busy SHALL be 1 in REQ, XFER and CMPLT.

Reset
REQ-035 While Bus2IP_Resetn=0: FSM=IDLE, counter=0, pending invalid, cmd_addr=0, Req=0, dst_rdy_n=1, fifo_wr_en=0, busy=0, overrun=0, bus_err=0; assertion mid-burst SHALL take effect immediately (asynchronous).

Verification
REQ-036 go_fill_fifo with addr 0x1000_0000, CmdAck after 3 cycles, 64 beats, then Cmplt -> Req high for exactly 3 cycles, Addr=0x1000_0000, Length=256, 64 fifo_wr_en pulses, return to IDLE.
REQ-037 fifo_full held high for beats 10-19 -> dst_rdy_n=1 for those cycles, no writes; total writes still 64 with data order preserved.
REQ-038 Second go (0x100) mid-burst, third go (0x200) mid-burst -> after Cmplt, next Req Addr=0x100; 0x200 never issued; overrun=1.
REQ-039 Pending 0x100 queued, then flush -> no second Req; busy drops after Cmplt.
REQ-040 Cmplt after 40 beats -> IDLE, bus_err=1; a following go issues normally.
REQ-041 Resetn pulled low during beat 30 -> all outputs at reset values asynchronously; after release, a new go starts a full 64-beat burst.
